atm_session_ctrl: RTL and testbench

Parametrised multi-account ATM session controller that supersedes the single-account ATM FSM in the front-panel design. It sits between the debounced switch/button inputs and the LED, seven-segment and buzzer drivers. It adds NUM_ACCTS registered balances, per-account PIN check with retry lockout, overflow-safe deposits and an inactivity timeout.

---
 rtl/atm_pkg.sv | 25 ++
 rtl/atm_session_ctrl_if.sv | 28 ++
 rtl/atm_acct_bank.sv | 29 ++
 rtl/atm_session_ctrl.sv | 155 +++++++++++++++
 tb/tb_atm_session_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// atm_pkg: shared state encoding, menu codes and LED bit positions for the ATM session controller
package atm_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_CARD_CHECK, S_PIN, S_MENU, S_PREVIEW, S_AMOUNT, S_EXECUTE, S_SHOW, S_EXIT
    } state_t;
    localparam logic [2:0] M_BAL   = 3'd1;
    localparam logic [2:0] M_RAPID = 3'd2;
    localparam logic [2:0] M_WDRAW = 3'd3;
    localparam logic [2:0] M_DEP   = 3'd4;
    localparam logic [2:0] M_EXIT  = 3'd5;
    localparam int L_CARD_OK  = 0;
    localparam int L_CARD_BAD = 1;
    localparam int L_SHOW     = 2;
    localparam int L_PIN      = 3;
    localparam int L_WDRAW    = 4;
    localparam int L_DEP      = 5;
    localparam int L_LOCK     = 6;
    localparam int L_TMO      = 7;
    localparam int L_EXIT     = 8;
    localparam int L_FAIL     = 9;
    localparam int L_OK       = 10;
    function automatic logic legal_code(input logic [2:0] c);
        return c != 3'd0 && c <= M_EXIT;
    endfunction
endpackage

// File: rtl/atm_session_ctrl_if.sv
// atm_session_ctrl_if: front-panel inputs and display/driver outputs of the ATM session controller
interface atm_session_ctrl_if #(
    parameter int BAL_W     = 8,
    parameter int AMT_W     = 4,
    parameter int NUM_ACCTS = 4,
    parameter int PIN_W     = 4
);
    logic [1:0]                     card_input;
    logic [$clog2(NUM_ACCTS)-1:0]   card_acct;
    logic [PIN_W-1:0]               pin_in;
    logic                           pin_enter;
    logic [2:0]                     menu_input;
    logic                           confirm_btn;
    logic [AMT_W-1:0]               amount;
    logic [BAL_W-1:0]               balance_out;
    logic [10:0]                    leds;
    logic [3:0]                     seg_value;
    logic                           beep;
    logic [NUM_ACCTS-1:0]           locked;
    modport master (
        output card_input, card_acct, pin_in, pin_enter, menu_input, confirm_btn, amount,
        input  balance_out, leds, seg_value, beep, locked
    );
    modport slave (
        input  card_input, card_acct, pin_in, pin_enter, menu_input, confirm_btn, amount,
        output balance_out, leds, seg_value, beep, locked
    );
endinterface

// File: rtl/atm_acct_bank.sv
// atm_acct_bank: per-account balance registers and sticky lockout flags
module atm_acct_bank #(
    parameter int BAL_W     = 8,
    parameter int NUM_ACCTS = 4,
    parameter int INIT_BAL  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(NUM_ACCTS)-1:0]   rd_addr,
    output logic [BAL_W-1:0]               rd_data,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_ACCTS)-1:0]   wr_addr,
    input  logic [BAL_W-1:0]               wr_data,
    input  logic                           lock_en,
    input  logic [$clog2(NUM_ACCTS)-1:0]   lock_addr,
    output logic [NUM_ACCTS-1:0]           locked
);
    logic [NUM_ACCTS-1:0][BAL_W-1:0] bal_q;
    // balances take write-port updates; lock flags only ever set until reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bal_q  <= {NUM_ACCTS{BAL_W'(INIT_BAL)}};
            locked <= '0;
        end else begin
            if (wr_en) bal_q[wr_addr] <= wr_data;
            if (lock_en) locked[lock_addr] <= 1'b1;
        end
    assign rd_data = bal_q[rd_addr];
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: multi-account ATM session FSM with PIN lockout, safe arithmetic and idle timeout
module atm_session_ctrl import atm_pkg::*; #(
    parameter int              BAL_W       = 8,
    parameter int              AMT_W       = 4,
    parameter int              NUM_ACCTS   = 4,
    parameter int              PIN_W       = 4,
    parameter logic [PIN_W-1:0] DEFAULT_PIN = 'h5,
    parameter int              INIT_BAL    = 0,
    parameter int              RAPID_AMT   = 5,
    parameter int              MAX_TRIES   = 3,
    parameter int              TIMEOUT_CYC = 1000
) (
    input logic               clk,
    input logic               rst_n,
    atm_session_ctrl_if.slave bus
);
    localparam int ACCT_W = $clog2(NUM_ACCTS);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    state_t              state_q, state_d;
    logic [ACCT_W-1:0]   acct_q;
    logic [2:0]          mode_q, mode_d;
    logic [AMT_W-1:0]    amt_q, amt_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [TMO_W-1:0]    tmo_q;
    logic [10:0]         leds_d, leds_q;
    logic                beep_d, beep_q;
    logic [3:0]          seg_q;
    logic [BAL_W-1:0]    bal_out_q, rd_bal, wr_data;
    logic [BAL_W:0]      sum;
    logic [NUM_ACCTS-1:0] locked;
    logic                wr_en, lock_en, ok, withdraw, expire;
    atm_acct_bank #(.BAL_W(BAL_W), .NUM_ACCTS(NUM_ACCTS), .INIT_BAL(INIT_BAL)) u_bank (
        .clk(clk), .rst_n(rst_n), .rd_addr(acct_q), .rd_data(rd_bal),
        .wr_en(wr_en), .wr_addr(acct_q), .wr_data(wr_data),
        .lock_en(lock_en), .lock_addr(acct_q), .locked(locked)
    );
    // next state, event LEDs and bank writes; card removal beats timeout beats normal flow
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        amt_d    = amt_q;
        tries_d  = tries_q;
        leds_d   = '0;
        beep_d   = 1'b0;
        wr_en    = 1'b0;
        lock_en  = 1'b0;
        sum      = {1'b0, rd_bal} + (BAL_W + 1)'(amt_q);
        withdraw = mode_q != M_DEP;
        ok       = withdraw ? (BAL_W + 1)'(amt_q) <= {1'b0, rd_bal} : !sum[BAL_W];
        wr_data  = withdraw ? rd_bal - BAL_W'(amt_q) : sum[BAL_W-1:0];
        expire   = tmo_q == TMO_W'(TIMEOUT_CYC - 1) && !bus.pin_enter && !bus.confirm_btn;
        case (state_q)
            S_IDLE: state_d = bus.card_input != 2'b00 ? S_CARD_CHECK : S_IDLE;
            S_EXIT: begin
                state_d = S_IDLE;
                tries_d = '0;
                mode_d  = '0;
            end
            default:
                if (bus.card_input == 2'b00) state_d = S_EXIT;
                else if (expire) begin
                    state_d        = S_EXIT;
                    leds_d[L_TMO] = 1'b1;
                end else case (state_q)
                    S_CARD_CHECK:
                        if (bus.card_input == 2'b10 && !locked[acct_q]) begin
                            state_d            = S_PIN;
                            leds_d[L_CARD_OK] = 1'b1;
                            beep_d             = 1'b1;
                        end else begin
                            state_d             = S_EXIT;
                            leds_d[L_CARD_BAD] = 1'b1;
                        end
                    S_PIN:
                        if (bus.pin_enter) begin
                            if (bus.pin_in == DEFAULT_PIN) begin
                                state_d = S_MENU;
                                tries_d = '0;
                            end else begin
                                tries_d = tries_q + 1'b1;
                                beep_d  = 1'b1;
                                if (tries_d == TRY_W'(MAX_TRIES)) begin
                                    state_d         = S_EXIT;
                                    lock_en         = 1'b1;
                                    leds_d[L_LOCK] = 1'b1;
                                end else leds_d[L_FAIL] = 1'b1;
                            end
                        end
                    S_MENU:
                        if (legal_code(bus.menu_input)) begin
                            state_d = S_PREVIEW;
                            mode_d  = bus.menu_input;
                        end
                    S_PREVIEW:
                        if (bus.confirm_btn) begin
                            state_d = mode_q == M_BAL ? S_SHOW :
                                      mode_q == M_RAPID ? S_EXECUTE :
                                      mode_q == M_EXIT ? S_EXIT : S_AMOUNT;
                            amt_d   = AMT_W'(RAPID_AMT);
                        end else if (legal_code(bus.menu_input)) mode_d = bus.menu_input;
                    S_AMOUNT:
                        if (bus.confirm_btn) begin
                            state_d = S_EXECUTE;
                            amt_d   = bus.amount;
                        end
                    S_EXECUTE: begin
                        state_d             = S_MENU;
                        wr_en               = ok;
                        beep_d              = 1'b1;
                        leds_d[ok ? L_OK : L_FAIL] = 1'b1;
                    end
                    S_SHOW: state_d = bus.confirm_btn ? S_MENU : S_SHOW;
                    default: state_d = S_EXIT;
                endcase
        endcase
        leds_d[L_PIN]   = state_d == S_PIN;
        leds_d[L_SHOW]  = state_d == S_SHOW;
        leds_d[L_WDRAW] = state_d == S_AMOUNT && mode_d == M_WDRAW;
        leds_d[L_DEP]   = state_d == S_AMOUNT && mode_d == M_DEP;
        leds_d[L_EXIT]  = state_d == S_EXIT;
        beep_d          = beep_d | (state_d == S_EXIT);
    end
    // state, session context, idle counter and registered outputs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acct_q    <= '0;
            mode_q    <= '0;
            amt_q     <= '0;
            tries_q   <= '0;
            tmo_q     <= '0;
            leds_q    <= '0;
            beep_q    <= 1'b0;
            seg_q     <= '0;
            bal_out_q <= '0;
        end else begin
            state_q   <= state_d;
            acct_q    <= state_q == S_IDLE ? bus.card_acct : acct_q;
            mode_q    <= mode_d;
            amt_q     <= amt_d;
            tries_q   <= tries_d;
            tmo_q     <= (state_d != state_q || bus.pin_enter || bus.confirm_btn ||
                          state_q == S_IDLE || state_q == S_EXIT) ? '0 : tmo_q + 1'b1;
            leds_q    <= leds_d;
            beep_q    <= beep_d;
            seg_q     <= state_d == S_PREVIEW ? {1'b0, mode_d} : 4'd0;
            bal_out_q <= state_d == S_SHOW ? rd_bal : '0;
        end
    assign bus.leds        = leds_q;
    assign bus.beep        = beep_q;
    assign bus.seg_value   = seg_q;
    assign bus.balance_out = bal_out_q;
    assign bus.locked      = locked;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed self-checking bench for the ATM session controller
module tb_atm_session_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    atm_session_ctrl_if bus ();
    atm_session_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic login(input logic [1:0] acct);
        bus.card_input = 2'b10;
        bus.card_acct  = acct;
        tick(2);
        chk("pin_leds", 32'(bus.leds), 32'h009);
        chk("pin_beep", 32'(bus.beep), 32'h1);
        bus.pin_in    = 4'h5;
        bus.pin_enter = 1'b1;
        tick(1);
        bus.pin_enter = 1'b0;
        chk("menu_leds", 32'(bus.leds), 32'h000);
    endtask

    task automatic pick(input logic [2:0] code);
        bus.menu_input = code;
        tick(1);
        bus.menu_input  = 3'd0;
        bus.confirm_btn = 1'b1;
        tick(1);
        bus.confirm_btn = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [2:0] code, input logic [3:0] amt, input logic [10:0] want);
        pick(code);
        if (code != 3'd2) begin
            bus.amount      = amt;
            bus.confirm_btn = 1'b1;
            tick(1);
            bus.confirm_btn = 1'b0;
        end
        tick(1);
        chk(tag, 32'(bus.leds), 32'(want));
    endtask

    task automatic show(input string tag, input logic [7:0] want);
        pick(3'd1);
        chk(tag, 32'(bus.balance_out), 32'(want));
        chk("show_leds", 32'(bus.leds), 32'h004);
        bus.confirm_btn = 1'b1;
        tick(1);
        bus.confirm_btn = 1'b0;
    endtask

    task automatic logout();
        pick(3'd5);
        chk("exit_leds", 32'(bus.leds), 32'h100);
        bus.card_input = 2'b00;
        tick(1);
    endtask

    initial begin
        bus.card_input = 2'b00; bus.card_acct = '0; bus.pin_in = '0; bus.pin_enter = 1'b0;
        bus.menu_input = 3'd0; bus.confirm_btn = 1'b0; bus.amount = '0;
        tick(2);
        rst_n = 1'b1;
        chk("rst_leds", 32'(bus.leds), 32'h0);
        chk("rst_beep", 32'(bus.beep), 32'h0);
        chk("rst_locked", 32'(bus.locked), 32'h0);
        chk("rst_seg", 32'(bus.seg_value), 32'h0);
        chk("rst_bal", 32'(bus.balance_out), 32'h0);
        // deposit 9 into account 2, with a preview re-latch on the way
        login(2'd2);
        bus.menu_input = 3'd1;
        tick(1);
        chk("seg_first", 32'(bus.seg_value), 32'h1);
        bus.menu_input = 3'd4;
        tick(1);
        chk("seg_relatch", 32'(bus.seg_value), 32'h4);
        bus.menu_input  = 3'd0;
        bus.confirm_btn = 1'b1;
        tick(1);
        bus.confirm_btn = 1'b0;
        chk("dep_amount_led", 32'(bus.leds), 32'h020);
        bus.amount      = 4'd9;
        bus.confirm_btn = 1'b1;
        tick(2);
        bus.confirm_btn = 1'b0;
        chk("dep9_ok", 32'(bus.leds), 32'h400);
        chk("dep9_beep", 32'(bus.beep), 32'h1);
        tick(1);
        chk("ok_pulse_end", 32'(bus.leds), 32'h000);
        show("bal2_9", 8'd9);
        chk("other_accts", dut.u_bank.bal_q, 32'h0009_0000);
        logout();
        chk("idle_leds", 32'(bus.leds), 32'h000);
        // invalid card
        bus.card_input = 2'b01;
        tick(2);
        chk("bad_card", 32'(bus.leds), 32'h102);
        bus.card_input = 2'b00;
        tick(1);
        // account 0: overdraw rejected, rapid withdraw to exactly zero
        login(2'd0);
        txn("dep3", 3'd4, 4'd3, 11'h400);
        txn("wd7_fail", 3'd3, 4'd7, 11'h200);
        show("bal0_3", 8'd3);
        txn("dep2", 3'd4, 4'd2, 11'h400);
        txn("rapid_ok", 3'd2, 4'd0, 11'h400);
        show("bal0_0", 8'd0);
        logout();
        // account 3: fill to 250, overflow rejected, exact 255 accepted
        login(2'd3);
        for (int i = 0; i < 16; i++) txn("dep15", 3'd4, 4'd15, 11'h400);
        txn("dep10", 3'd4, 4'd10, 11'h400);
        txn("dep9_ovf", 3'd4, 4'd9, 11'h200);
        show("bal3_250", 8'd250);
        txn("dep5_max", 3'd4, 4'd5, 11'h400);
        show("bal3_255", 8'd255);
        logout();
        // three wrong PINs lock account 1
        bus.card_input = 2'b10;
        bus.card_acct  = 2'd1;
        tick(2);
        bus.pin_in = 4'h3;
        for (int i = 0; i < 2; i++) begin
            bus.pin_enter = 1'b1;
            tick(1);
            bus.pin_enter = 1'b0;
            chk("bad_pin", 32'(bus.leds), 32'h208);
            tick(1);
        end
        bus.pin_enter = 1'b1;
        tick(1);
        bus.pin_enter = 1'b0;
        chk("lockout_leds", 32'(bus.leds), 32'h140);
        chk("locked_flag", 32'(bus.locked), 32'h2);
        bus.card_input = 2'b00;
        tick(1);
        bus.card_input = 2'b10;
        tick(2);
        chk("locked_reinsert", 32'(bus.leds), 32'h102);
        bus.card_input = 2'b00;
        tick(1);
        // idle timeout in MENU, first rescued by a confirm in the expiry cycle
        login(2'd0);
        tick(999);
        chk("pre_expiry", 32'(bus.leds), 32'h000);
        bus.confirm_btn = 1'b1;
        tick(1);
        bus.confirm_btn = 1'b0;
        chk("strobe_wins", 32'(bus.leds), 32'h000);
        tick(999);
        chk("still_menu", 32'(bus.leds), 32'h000);
        tick(1);
        chk("timeout_exit", 32'(bus.leds), 32'h180);
        bus.card_input = 2'b00;
        tick(1);
        chk("timeout_idle", 32'(bus.leds), 32'h000);
        // card pulled during AMOUNT
        login(2'd2);
        pick(3'd3);
        chk("wd_amount_led", 32'(bus.leds), 32'h010);
        bus.card_input = 2'b00;
        tick(1);
        chk("pull_exit", 32'(bus.leds), 32'h100);
        tick(1);
        chk("pull_bal", dut.u_bank.bal_q, 32'hFF09_0000);
        // reset asserted during EXECUTE
        login(2'd2);
        pick(3'd4);
        bus.amount      = 4'd5;
        bus.confirm_btn = 1'b1;
        tick(1);
        bus.confirm_btn = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_exec_bal", dut.u_bank.bal_q, 32'h0);
        chk("rst_exec_locked", 32'(bus.locked), 32'h0);
        chk("rst_exec_leds", 32'(bus.leds), 32'h0);
        bus.card_input = 2'b00;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        login(2'd1);
        chk("post_rst_bal", dut.u_bank.bal_q, 32'h0);
        logout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
